fp_accumulate: RTL and testbench
================================

// Module: fp_accumulate
// PURPOSE
//   Sequential floating-point reduction stage that sits directly downstream of the FP multiplier.
//   Consumes a stream of products in the same sign/8-bit-exponent/MANTISSA format.
//   Sums each vector, delimited by in_last, into a single value.
//   Emits that value on a valid/ready output; this is the accumulate half of the dot-product path.
// PARAMETERS
//   MANTISSA  8   fraction bits; WIDTH = 1+8+MANTISSA (exponent fixed at 8 bits, bias 127)
//   GUARD     2   extra low-order bits kept through align/add, dropped at normalise
//   COUNT_W   16  width of element counter
// PORTS
//   clk        in   1         clock, all state on rising edge
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         product word valid
//   in_ready   out  1         stage can accept a product
//   in_data    in   WIDTH     product {sign, exp[7:0], frac[MANTISSA-1:0]}
//   in_last    in   1         this product is the final element of the vector
//   out_valid  out  1         accumulated sum valid
//   out_ready  in   1         consumer takes sum
//   out_data   out  WIDTH     accumulated sum, same format
//   out_count  out  COUNT_W   number of elements summed into out_data (saturates at all-ones)
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - state=ACCEPT, acc=+0, count=0; in_ready=1, out_valid=0, out_data=0, out_count=0.
//     - Reset mid-operation discards the partial sum and any in-flight element.
//   FSM: ACCEPT -> ALIGN -> ADD -> NORM -> (ACCEPT | OUTPUT)
//     - ACCEPT: in_ready=1; on in_valid, latch in_data/in_last, go ALIGN. Stays otherwise.
//     - ALIGN: order operands by magnitude {exp,frac}; right-shift smaller significand by exp diff.
//       Shift saturates at MANTISSA+GUARD+1 (operand becomes 0).
//     - ADD: add or subtract aligned significands per sign XOR; result sign = larger operand sign.
//     - NORM: on carry, shift right 1 and exp+1; else left-shift by leading-zero count and exp-=lzc.
//       Truncate guard bits (round toward zero). Write acc, count+=1 (saturating).
//       Go OUTPUT if latched last, else ACCEPT.
//     - OUTPUT: out_valid=1, out_data=acc, out_count=count, all held stable until out_ready.
//       On out_valid&&out_ready: acc=+0, count=0, go ACCEPT. in_ready=0 here.
//   Timing
//     - One accepted element every 4 cycles; in_ready low in ALIGN/ADD/NORM/OUTPUT.
//     - Sum valid on the 4th cycle after the last handshake.
//   Special values
//     - Exp==0 input: flushed to signed zero (no denormals).
//     - NaN in either operand: result is canonical NaN {1, 8'hFF, 1, 0...}; sticky for rest of vector.
//     - inf + finite = that inf; +inf + -inf = canonical NaN.
//     - Result exp >= 255: signed inf. Result exp <= 0: +0.
//     - Exact cancellation gives +0.
//     - A vector of one element returns that element (with flush applied).
// TESTING (MANTISSA=8, WIDTH=17)
//   1. Stream 0x07F00, 0x08000, 0x08080(last), out_ready=1
//      -> out_data=0x08180 (6.0), out_count=3, in_ready low 3 cycles after each accept.
//   2. 0x07F00, 0x17F00(last) -> out_data=0x00000 (+0), out_count=2.
//   3. 0x0FF00, 0x1FF00(last) -> 0x1FF80 (NaN).
//      Then 0x07F80(last) -> 0x07F80: acc was cleared after output.
//   4. Output backpressure: hold out_ready=0 for 10 cycles
//      -> out_valid/out_data/out_count stable, in_ready=0, in_valid ignored; sum released when out_ready=1.
//   5. Overflow: 0x0FE00, 0x0FE00(last) -> 0x0FF00 (+inf).
//      Denormal 0x00055 + 0x07F00(last) -> 0x07F00.
//   6. Assert rst_n=0 in ADD state of a 3-element vector
//      -> immediate out_valid=0, in_ready=1.
//      Then a single element 0x08000(last) -> out_data=0x08000, out_count=1.

Source files
------------

// File: rtl/fp_accumulate.sv
// fp_accumulate: sequential floating-point reducer. Each accepted product is
// added into a running sum over four cycles (ACCEPT/ALIGN/ADD/NORM). The sum of
// a vector, closed by in_last, is presented on a valid/ready output.
module fp_accumulate #(
    parameter int MANTISSA = 8,
    parameter int GUARD    = 2,
    parameter int COUNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MANTISSA+8:0]   in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MANTISSA+8:0]   out_data,
    output logic [COUNT_W-1:0]    out_count
);

    localparam int WIDTH = MANTISSA + 9;
    // hidden bit + fraction + guard bits
    localparam int SIG_W = MANTISSA + GUARD + 1;
    localparam int LZC_W = $clog2(SIG_W + 1);
    localparam logic [WIDTH-1:0] QNAN = {1'b1, 8'hFF, 1'b1, {(MANTISSA-1){1'b0}}};

    typedef enum logic [2:0] {
        S_ACCEPT,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_OUTPUT
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]     opb_q;
    logic                 last_q;
    logic                 special_q, special_d;
    logic [WIDTH-1:0]     special_val_q, special_val_d;
    logic [SIG_W-1:0]     big_sig_q, big_sig_d;
    logic [SIG_W-1:0]     small_sig_q, small_sig_d;
    logic [7:0]           big_exp_q, big_exp_d;
    logic                 res_sign_q, res_sign_d;
    logic                 sub_q, sub_d;
    logic [SIG_W:0]       sum_q, sum_d;

    // Operand fields: a is the running sum, b the latched product.
    logic                 a_sign, b_sign;
    logic [7:0]           a_exp, b_exp;
    logic [MANTISSA-1:0]  a_frac, b_frac;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign {a_sign, a_exp, a_frac} = acc_q;
    assign {b_sign, b_exp, b_frac} = opb_q;
    assign a_zero = (a_exp == 8'h00);
    assign b_zero = (b_exp == 8'h00);
    assign a_inf  = (a_exp == 8'hFF) && (a_frac == '0);
    assign b_inf  = (b_exp == 8'hFF) && (b_frac == '0);
    assign a_nan  = (a_exp == 8'hFF) && (a_frac != '0);
    assign b_nan  = (b_exp == 8'hFF) && (b_frac != '0);

    // Magnitude ordering and alignment of the smaller significand.
    logic                 a_ge_b;
    logic [7:0]           small_exp, exp_diff;
    logic [MANTISSA-1:0]  big_frac, small_frac;
    logic [SIG_W-1:0]     small_full;

    assign a_ge_b      = {a_exp, a_frac} >= {b_exp, b_frac};
    assign big_exp_d   = a_ge_b ? a_exp  : b_exp;
    assign small_exp   = a_ge_b ? b_exp  : a_exp;
    assign big_frac    = a_ge_b ? a_frac : b_frac;
    assign small_frac  = a_ge_b ? b_frac : a_frac;
    assign res_sign_d  = a_ge_b ? a_sign : b_sign;
    assign sub_d       = a_sign ^ b_sign;
    assign exp_diff    = big_exp_d - small_exp;
    assign big_sig_d   = {1'b1, big_frac, {GUARD{1'b0}}};
    assign small_full  = {1'b1, small_frac, {GUARD{1'b0}}};
    assign small_sig_d = (32'(exp_diff) >= SIG_W) ? '0 : (small_full >> exp_diff);

    // Special-value outcomes bypass the arithmetic; zero operands pass the other through.
    always_comb begin
        special_d     = 1'b1;
        special_val_d = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign)))
            special_val_d = QNAN;
        else if (a_inf)
            special_val_d = acc_q;
        else if (b_inf)
            special_val_d = opb_q;
        else if (a_zero)
            special_val_d = b_zero ? {b_sign, {(WIDTH-1){1'b0}}} : opb_q;
        else if (b_zero)
            special_val_d = acc_q;
        else
            special_d = 1'b0;
    end

    assign sum_d = sub_q ? ({1'b0, big_sig_q} - {1'b0, small_sig_q})
                         : ({1'b0, big_sig_q} + {1'b0, small_sig_q});

    // Normalisation: leading-zero count, exponent adjust, truncation and range clamp.
    logic [LZC_W-1:0]     lzc;
    logic [SIG_W-1:0]     norm_sig;
    logic signed [9:0]    norm_exp;
    logic                 unused_bits;

    assign unused_bits = ^{norm_sig[GUARD-1:0], norm_sig[SIG_W-1]};

    // Build the next accumulator value from the registered sum.
    always_comb begin
        lzc = LZC_W'(SIG_W);
        for (int i = 0; i < SIG_W; i++)
            if (sum_q[i]) lzc = LZC_W'(SIG_W - 1 - i);
        norm_sig = '0;
        norm_exp = '0;
        if (sum_q[SIG_W]) begin
            norm_sig = sum_q[SIG_W:1];
            norm_exp = $signed({2'b00, big_exp_q}) + 10'sd1;
        end else begin
            norm_sig = sum_q[SIG_W-1:0] << lzc;
            norm_exp = $signed({2'b00, big_exp_q}) - $signed({{(10-LZC_W){1'b0}}, lzc});
        end
        if (special_q)
            acc_d = special_val_q;
        else if ((sum_q == '0) || (norm_exp <= 10'sd0))
            acc_d = '0;
        else if (norm_exp >= 10'sd255)
            acc_d = {res_sign_q, 8'hFF, {MANTISSA{1'b0}}};
        else
            acc_d = {res_sign_q, norm_exp[7:0], norm_sig[SIG_W-2 -: MANTISSA]};
    end

    assign count_d = (&count_q) ? count_q : count_q + 1'b1;

    // Next-state selection for the four-cycle accumulate loop and output hold.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACCEPT: if (in_valid) state_d = S_ALIGN;
            S_ALIGN:  state_d = S_ADD;
            S_ADD:    state_d = S_NORM;
            S_NORM:   state_d = last_q ? S_OUTPUT : S_ACCEPT;
            S_OUTPUT: if (out_ready) state_d = S_ACCEPT;
            default:  state_d = S_ACCEPT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_ACCEPT;
        else        state_q <= state_d;
    end

    // Datapath registers, each loaded in the state that produces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q         <= '0;
            count_q       <= '0;
            opb_q         <= '0;
            last_q        <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            big_sig_q     <= '0;
            small_sig_q   <= '0;
            big_exp_q     <= '0;
            res_sign_q    <= 1'b0;
            sub_q         <= 1'b0;
            sum_q         <= '0;
        end else begin
            case (state_q)
                S_ACCEPT: if (in_valid) begin
                    opb_q  <= in_data;
                    last_q <= in_last;
                end
                S_ALIGN: begin
                    special_q     <= special_d;
                    special_val_q <= special_val_d;
                    big_sig_q     <= big_sig_d;
                    small_sig_q   <= small_sig_d;
                    big_exp_q     <= big_exp_d;
                    res_sign_q    <= res_sign_d;
                    sub_q         <= sub_d;
                end
                S_ADD: sum_q <= sum_d;
                S_NORM: begin
                    acc_q   <= acc_d;
                    count_q <= count_d;
                end
                S_OUTPUT: if (out_ready) begin
                    acc_q   <= '0;
                    count_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_ACCEPT);
    assign out_valid = (state_q == S_OUTPUT);
    assign out_data  = out_valid ? acc_q   : '0;
    assign out_count = out_valid ? count_q : '0;

endmodule

// File: tb/tb_fp_accumulate.sv
// Bench for fp_accumulate: directed scenarios followed by random vectors
// checked against an integer-arithmetic reference of the summation rules.
module tb_fp_accumulate;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_data;
    logic [15:0] out_count;

    int tests = 0;
    int fails = 0;

    localparam logic [16:0] NAN_C = 17'h1FF80;

    fp_accumulate #(.MANTISSA(8), .GUARD(2), .COUNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: sum of two values using integer significands scaled by 4 (two guard bits).
    function automatic logic [16:0] model_add(input logic [16:0] a, input logic [16:0] b_raw);
        logic [16:0] b;
        int ea, eb, fa, fb, e, d, r, m_big, m_small;
        bit sa, sb, s, an, bn, ai, bi;
        b = b_raw;
        if (b[15:8] == 8'h00) b = {b[16], 16'h0000};
        sa = a[16]; sb = b[16];
        ea = int'(a[15:8]); eb = int'(b[15:8]);
        fa = int'(a[7:0]);  fb = int'(b[7:0]);
        an = (ea == 255) && (fa != 0); bn = (eb == 255) && (fb != 0);
        ai = (ea == 255) && (fa == 0); bi = (eb == 255) && (fb == 0);
        if (an || bn) return NAN_C;
        if (ai && bi) return (sa == sb) ? a : NAN_C;
        if (ai) return a;
        if (bi) return b;
        if (ea == 0) return b;
        if (eb == 0) return a;
        if (ea * 256 + fa >= eb * 256 + fb) begin
            e = ea; s = sa; d = ea - eb;
            m_big = (256 + fa) * 4; m_small = (256 + fb) * 4;
        end else begin
            e = eb; s = sb; d = eb - ea;
            m_big = (256 + fb) * 4; m_small = (256 + fa) * 4;
        end
        if (d > 20) m_small = 0;
        else        m_small = m_small / (1 << d);
        r = (sa == sb) ? m_big + m_small : m_big - m_small;
        if (r == 0) return 17'h00000;
        while (r >= 2048) begin r = r / 2; e++; end
        while (r < 1024)  begin r = r * 2; e--; end
        if (e >= 255) return {s, 8'hFF, 8'h00};
        if (e <= 0)   return 17'h00000;
        return {s, 8'(e), 8'((r / 4) % 256)};
    endfunction

    function automatic logic [16:0] rand_elem();
        int k;
        logic s;
        logic [7:0] f;
        k = $urandom_range(0, 19);
        s = 1'($urandom_range(0, 1));
        f = 8'($urandom_range(0, 255));
        case (k)
            0: return {s, 8'h00, f};
            1: return {s, 8'hFF, 8'h00};
            2: return {s, 8'hFF, 8'h01 | f};
            3: return {s, 8'hFE, f};
            4: return {s, 8'h01, f};
            default: return {s, 8'(120 + $urandom_range(0, 15)), f};
        endcase
    endfunction

    // Present one element and hold it until the stage takes it.
    task automatic send(input logic [16:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("send_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = d; in_last = l;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Wait for the sum, compare it, then complete the output handshake.
    task automatic recv(input logic [16:0] ed, input logic [15:0] ec, input string tag, output int lat);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        lat = n;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(ed));
        check({tag, "_count"}, 32'(out_count), 32'(ec));
        $display("[TB] %s: data=0x%05h count=%0d (want 0x%05h/%0d)", tag, out_data, out_count, ed, ec);
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    // After accepting a non-final element, in_ready stays low for three cycles.
    task automatic check_gap(input string tag);
        check({tag, "_busy_align"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        check({tag, "_busy_add"},   32'(in_ready), 32'd0);
        @(negedge clk);
        check({tag, "_busy_norm"},  32'(in_ready), 32'd0);
        @(negedge clk);
        check({tag, "_ready"},      32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int len;
        logic [16:0] acc;
        logic [16:0] e;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;

        // 1.0 + 2.0 + 3.0 = 6.0, with accept spacing and output latency
        send(17'h07F00, 1'b0); check_gap("t1_e0");
        send(17'h08000, 1'b0); check_gap("t1_e1");
        send(17'h08080, 1'b1);
        recv(17'h08180, 16'd3, "t1_sum", lat);
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_valid_drop", 32'(out_valid), 32'd0);

        // exact cancellation
        send(17'h07F00, 1'b0); send(17'h17F00, 1'b1);
        recv(17'h00000, 16'd2, "t2_cancel", lat);

        // +inf + -inf, then a fresh vector proves the sum was cleared
        send(17'h0FF00, 1'b0); send(17'h1FF00, 1'b1);
        recv(NAN_C, 16'd2, "t3_nan", lat);
        send(17'h07F80, 1'b1);
        recv(17'h07F80, 16'd1, "t3_fresh", lat);

        // output backpressure: everything frozen, inputs ignored
        out_ready = 1'b0;
        send(17'h07F00, 1'b0); send(17'h07F00, 1'b1);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        for (int c = 0; c < 10; c++) begin
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_data",  32'(out_data),  32'h08000);
            check("t4_hold_count", 32'(out_count), 32'd2);
            check("t4_in_ready",   32'(in_ready),  32'd0);
            in_valid = 1'b1; in_data = 17'h0FF80; in_last = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        recv(17'h08000, 16'd2, "t4_release", lat);
        send(17'h07F00, 1'b1);
        recv(17'h07F00, 16'd1, "t4_clean", lat);

        // overflow to +inf, denormal flushed to zero
        send(17'h0FE00, 1'b0); send(17'h0FE00, 1'b1);
        recv(17'h0FF00, 16'd2, "t5_ovf", lat);
        send(17'h00055, 1'b0); send(17'h07F00, 1'b1);
        recv(17'h07F00, 16'd2, "t5_denorm", lat);

        // reset while the second element of a vector is in ADD
        send(17'h07F00, 1'b0); send(17'h08000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send(17'h08000, 1'b1);
        recv(17'h08000, 16'd1, "t6_single", lat);

        // random vectors against the reference
        for (int v = 0; v < 30; v++) begin
            len = $urandom_range(1, 5);
            acc = 17'h00000;
            out_ready = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < len; k++) begin
                e = rand_elem();
                acc = model_add(acc, e);
                send(e, k == len - 1);
            end
            recv(acc, 16'(len), $sformatf("rnd%0d", v), lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
